// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

  // Bus geometry of the peripheral Wishbone segment.
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;

  // Arbiter FSM: idle, or locked onto one master for its whole cyc.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_t;

  // Master identifiers as stored in last_grant.
  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  // One-hot grant vector for a given state: [0] = m0, [1] = m1.
  function automatic logic [1:0] grant_onehot(input arb_state_t s);
    logic [1:0] g;
    g = 2'b00;
    case (s)
      ARB_GRANT0: g = 2'b01;
      ARB_GRANT1: g = 2'b10;
      default:    g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// Classic Wishbone bundle. Peripheral faces an upstream master,
// Controller drives a downstream slave.
interface Wishbone;
  import wb_arb_pkg::*;

  logic             cyc;
  logic             stb;
  logic             we;
  logic [WB_SW-1:0] sel;
  logic [WB_AW-1:0] addr;
  logic [WB_DW-1:0] data_wr;
  logic [WB_DW-1:0] data_rd;
  logic             ack;
  logic             err;

  modport Peripheral (
    input  cyc, stb, we, sel, addr, data_wr,
    output data_rd, ack, err
  );

  modport Controller (
    output cyc, stb, we, sel, addr, data_wr,
    input  data_rd, ack, err
  );

endinterface

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts cycles a strobe waits for a response and fires
// when the wait reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables it.
module wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CTR_WIDTH      = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_active,  // downstream stb is high
  input  logic i_done,    // slave answered with ack or err
  output logic o_fire
);

  localparam logic                 ENABLED = (TIMEOUT_CYCLES > 0);
  localparam logic [CTR_WIDTH-1:0] TERM    = CTR_WIDTH'(TIMEOUT_CYCLES);

  logic [CTR_WIDTH-1:0] ctr_q, ctr_d;
  logic                 hit;

  // Terminal count is compared against the registered count, so the
  // forced err lands TIMEOUT_CYCLES cycles after stb first rises.
  assign hit = ENABLED && (ctr_q == TERM);

  // A real response in the terminal cycle wins over the watchdog.
  assign o_fire = i_active && !i_done && hit;

  // Next count: restart on any response, idle strobe, or firing.
  always_comb begin
    ctr_d = ctr_q + 1'b1;
    if (!ENABLED || !i_active || i_done || hit) begin
      ctr_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone arbiter. Round-robin on ties, grant
// locked for a master's whole cyc, watchdog turns a silent slave into err.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  Wishbone.Peripheral          wb_m0,
  Wishbone.Peripheral          wb_m1,
  Wishbone.Controller          wb_s,
  output logic [1:0]           o_grant,
  output logic                 o_timeout
);

  // Guarded so a disabled watchdog still gets a legal 1-bit counter.
  localparam int CTR_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t state_q, state_d;
  logic       last_q, last_d;   // master granted most recently
  logic       req0, req1;
  logic       wd_fire;

  assign req0 = wb_m0.cyc && wb_m0.stb;
  assign req1 = wb_m1.cyc && wb_m1.stb;

  // Next-state: arbitrate only from IDLE; a grant holds until its cyc
  // drops or the watchdog fires, so multi-beat cycles are never split.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (req0 && req1) begin
          if (last_q == ARB_M1) begin
            state_d = ARB_GRANT0;
            last_d  = ARB_M0;
          end else begin
            state_d = ARB_GRANT1;
            last_d  = ARB_M1;
          end
        end else if (req0) begin
          state_d = ARB_GRANT0;
          last_d  = ARB_M0;
        end else if (req1) begin
          state_d = ARB_GRANT1;
          last_d  = ARB_M1;
        end
      end
      ARB_GRANT0: begin
        if (!wb_m0.cyc || wd_fire) state_d = ARB_IDLE;
      end
      ARB_GRANT1: begin
        if (!wb_m1.cyc || wd_fire) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and round-robin history; reset makes m0 win the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
      last_q  <= ARB_M1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Read data is shared; only ack/err need steering.
  assign wb_m0.data_rd = wb_s.data_rd;
  assign wb_m1.data_rd = wb_s.data_rd;

  // Request mux toward the slave and response steering back to the
  // granted master. In IDLE the slave sees a quiet bus and any stray
  // response (e.g. a late ack after reset) is dropped.
  always_comb begin
    wb_s.cyc     = 1'b0;
    wb_s.stb     = 1'b0;
    wb_s.we      = 1'b0;
    wb_s.sel     = '0;
    wb_s.addr    = '0;
    wb_s.data_wr = '0;
    wb_m0.ack    = 1'b0;
    wb_m0.err    = 1'b0;
    wb_m1.ack    = 1'b0;
    wb_m1.err    = 1'b0;
    case (state_q)
      ARB_GRANT0: begin
        wb_s.cyc     = wb_m0.cyc;
        wb_s.stb     = wb_m0.stb;
        wb_s.we      = wb_m0.we;
        wb_s.sel     = wb_m0.sel;
        wb_s.addr    = wb_m0.addr;
        wb_s.data_wr = wb_m0.data_wr;
        wb_m0.ack    = wb_s.ack;
        wb_m0.err    = wb_s.err || wd_fire;
      end
      ARB_GRANT1: begin
        wb_s.cyc     = wb_m1.cyc;
        wb_s.stb     = wb_m1.stb;
        wb_s.we      = wb_m1.we;
        wb_s.sel     = wb_m1.sel;
        wb_s.addr    = wb_m1.addr;
        wb_s.data_wr = wb_m1.data_wr;
        wb_m1.ack    = wb_s.ack;
        wb_m1.err    = wb_s.err || wd_fire;
      end
      default: ;
    endcase
  end

  wb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CTR_WIDTH      (CTR_WIDTH)
  ) u_wdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_active (wb_s.stb),
    .i_done   (wb_s.ack || wb_s.err),
    .o_fire   (wd_fire)
  );

  assign o_grant   = grant_onehot(state_q);
  assign o_timeout = wd_fire;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 with a small RAM slave model.
module tb_wb_arbiter2;
  import wb_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       tmo;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  Wishbone m0();
  Wishbone m1();
  Wishbone s();

  wb_arbiter2 #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .wb_m0    (m0),
    .wb_m1    (m1),
    .wb_s     (s),
    .o_grant  (grant),
    .o_timeout(tmo)
  );

  // RAM slave: registered response, LAT extra cycles, err above 0xFF,
  // silent when no_resp. Once accepted a request always completes.
  logic [31:0] mem [0:63];
  int          lat = 0;
  bit          no_resp = 1'b0;
  logic        pend = 1'b0;
  int          wcnt = 0;
  logic [31:0] p_addr = '0, p_dat = '0;
  logic        p_we = 1'b0;
  logic        s_ack_q = 1'b0, s_err_q = 1'b0;
  logic [31:0] s_rd_q = '0;
  logic        acc, go, gw;
  logic [31:0] ga, gd;

  assign s.ack     = s_ack_q;
  assign s.err     = s_err_q;
  assign s.data_rd = s_rd_q;

  always_comb begin
    acc = s.cyc && s.stb && !s_ack_q && !s_err_q && !no_resp && !pend;
    go  = (pend && wcnt == 0) || (acc && lat == 0);
    ga  = pend ? p_addr : s.addr;
    gw  = pend ? p_we   : s.we;
    gd  = pend ? p_dat  : s.data_wr;
  end

  always @(posedge clk) begin
    s_ack_q <= 1'b0;
    s_err_q <= 1'b0;
    if (pend && wcnt != 0) wcnt <= wcnt - 1;
    if (go) begin
      pend <= 1'b0;
      if (ga >= 32'h100) s_err_q <= 1'b1;
      else begin
        s_ack_q <= 1'b1;
        s_rd_q  <= mem[ga[7:2]];
        if (gw) mem[ga[7:2]] <= gd;
      end
    end else if (acc && lat != 0) begin
      pend   <= 1'b1;
      wcnt   <= lat - 1;
      p_addr <= s.addr;
      p_dat  <= s.data_wr;
      p_we   <= s.we;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int m, input logic cyc, input logic stb, input logic we,
                     input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0.cyc = cyc; m0.stb = stb; m0.we = we; m0.sel = 4'hF; m0.addr = a; m0.data_wr = d;
    end else begin
      m1.cyc = cyc; m1.stb = stb; m1.we = we; m1.sel = 4'hF; m1.addr = a; m1.data_wr = d;
    end
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0.ack : m1.ack;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    repeat (3) tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b exp 00", grant); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b exp 0", tmo); end
    checks++; if ({s.cyc, s.stb, s.we} !== 3'b000) begin errors++; $display("FAIL rst_bus: got cyc/stb/we %b exp 000", {s.cyc, s.stb, s.we}); end
    checks++; if (s.sel !== 4'h0) begin errors++; $display("FAIL rst_sel: got %h exp 0", s.sel); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    lat = 0;
    drv(0, 1, 1, 0, 32'h10, 0);
    checks++; if (s.stb !== 1'b0) begin errors++; $display("FAIL rd_stb_t0: got %b exp 0", s.stb); end
    tick();
    checks++; if (s.stb !== 1'b1) begin errors++; $display("FAIL rd_stb_t1: got %b exp 1", s.stb); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rd_grant: got %b exp 01", grant); end
    checks++; if (s.addr !== 32'h10) begin errors++; $display("FAIL rd_addr: got %h exp 10", s.addr); end
    checks++; if (m0.ack !== 1'b0) begin errors++; $display("FAIL rd_ack_t1: got %b exp 0", m0.ack); end
    tick();
    checks++; if (m0.ack !== 1'b1) begin errors++; $display("FAIL rd_ack_t2: got %b exp 1", m0.ack); end
    checks++; if (m0.data_rd !== 32'hA000_0004) begin errors++; $display("FAIL rd_data: got %h exp a0000004", m0.data_rd); end
    checks++; if (m1.ack !== 1'b0) begin errors++; $display("FAIL rd_m1_ack: got %b exp 0", m1.ack); end
    checks++; if (m1.data_rd !== 32'hA000_0004) begin errors++; $display("FAIL rd_bcast: got %h exp a0000004", m1.data_rd); end
    drv(0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rd_release: got %b exp 00", grant); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [12] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                               2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    int rem [2] = '{1, 1};
    bit act [2] = '{1'b1, 1'b1};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv(0, 1, 1, 0, 32'h30, 0);
    drv(1, 1, 1, 0, 32'h34, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (grant !== exp_g[i]) begin errors++; $display("FAIL rr_grant[%0d]: got %b exp %b", i, grant, exp_g[i]); end
      for (int m = 0; m < 2; m++) begin
        if (act[m] && ack_of(m)) begin
          drv(m, 0, 0, 0, 0, 0);
          act[m] = 1'b0;
        end else if (!act[m] && rem[m] > 0) begin
          drv(m, 1, 1, 0, 32'h30 + 32'(m * 4), 0);
          act[m] = 1'b1;
          rem[m]--;
        end
      end
    end
  endtask

  task automatic test_locked_burst();
    logic [31:0] dat [3] = '{32'h1111_0020, 32'h2222_0024, 32'h3333_0028};
    logic [1:0]  exp_g [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
    int beat = 0;
    drv(1, 1, 1, 1, 32'h20, dat[0]);
    tick();
    drv(0, 1, 1, 0, 32'h50, 0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      checks++; if (grant !== exp_g[i]) begin errors++; $display("FAIL burst_grant[%0d]: got %b exp %b", i, grant, exp_g[i]); end
      checks++; if (m0.ack !== (i == 8)) begin errors++; $display("FAIL burst_m0_ack[%0d]: got %b exp %b", i, m0.ack, (i == 8)); end
      if (m0.ack) drv(0, 0, 0, 0, 0, 0);
      if (m1.ack && beat < 3) begin
        beat++;
        if (beat == 3) drv(1, 0, 0, 0, 0, 0);
        else drv(1, 1, 1, 1, 32'h20 + 32'(beat * 4), dat[beat]);
      end
    end
    tick();
    checks++; if (beat !== 3) begin errors++; $display("FAIL burst_beats: got %0d exp 3", beat); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (mem[8 + k] !== dat[k]) begin errors++; $display("FAIL burst_mem[%0d]: got %h exp %h", k, mem[8 + k], dat[k]); end
    end
  endtask

  task automatic test_timeout();
    no_resp = 1'b1;
    drv(0, 1, 1, 0, 32'h4000_0000, 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++; if (m0.err !== (k == 9)) begin errors++; $display("FAIL to_err[%0d]: got %b exp %b", k, m0.err, (k == 9)); end
      checks++; if (tmo !== (k == 9)) begin errors++; $display("FAIL to_pulse[%0d]: got %b exp %b", k, tmo, (k == 9)); end
    end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL to_grant: got %b exp 01", grant); end
    drv(0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL to_idle: got %b exp 00", grant); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL to_once: got %b exp 0", tmo); end
    no_resp = 1'b0;
  endtask

  task automatic test_ack_wins();
    lat = 7;
    drv(0, 1, 1, 0, 32'h14, 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL aw_pulse[%0d]: got %b exp 0", k, tmo); end
      checks++; if (m0.ack !== (k == 9)) begin errors++; $display("FAIL aw_ack[%0d]: got %b exp %b", k, m0.ack, (k == 9)); end
    end
    checks++; if (m0.err !== 1'b0) begin errors++; $display("FAIL aw_err: got %b exp 0", m0.err); end
    drv(0, 0, 0, 0, 0, 0);
    tick();
    lat = 0;
  endtask

  task automatic test_slave_err();
    drv(1, 1, 1, 1, 32'h1000, 32'hDEAD_BEEF);
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL serr_grant: got %b exp 10", grant); end
    tick();
    checks++; if (m1.err !== 1'b1) begin errors++; $display("FAIL serr_m1_err: got %b exp 1", m1.err); end
    checks++; if (m1.ack !== 1'b0) begin errors++; $display("FAIL serr_m1_ack: got %b exp 0", m1.ack); end
    checks++; if (m0.err !== 1'b0) begin errors++; $display("FAIL serr_m0_err: got %b exp 0", m0.err); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL serr_timeout: got %b exp 0", tmo); end
    drv(1, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_stb_hold();
    no_resp = 1'b1;
    drv(0, 1, 1, 0, 32'h4000_0000, 0);
    tick();
    drv(0, 1, 0, 0, 32'h4000_0000, 0);
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++; if (grant !== 2'b01 || tmo !== 1'b0) begin errors++; $display("FAIL hold[%0d]: got grant %b tmo %b exp 01 0", k, grant, tmo); end
    end
    drv(0, 1, 1, 0, 32'h4000_0000, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (m0.err !== (k == 8)) begin errors++; $display("FAIL hold_err[%0d]: got %b exp %b", k, m0.err, (k == 8)); end
    end
    drv(0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL hold_idle: got %b exp 00", grant); end
    no_resp = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    lat = 3;
    drv(0, 1, 1, 0, 32'h18, 0);
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rm_grant: got %b exp 01", grant); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rm_drop: got %b exp 00", grant); end
    checks++; if (s.cyc !== 1'b0) begin errors++; $display("FAIL rm_cyc: got %b exp 0", s.cyc); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      if (s.ack) seen = 1'b1;
      checks++; if (m0.ack !== 1'b0 || m1.ack !== 1'b0) begin errors++; $display("FAIL rm_late_ack[%0d]: got m0 %b m1 %b exp 0 0", k, m0.ack, m1.ack); end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rm_slave_ack: got %b exp 1", seen); end
    drv(0, 1, 1, 0, 32'h40, 0);
    drv(1, 1, 1, 0, 32'h44, 0);
    rst = 1'b0;
    lat = 0;
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rm_tie: got %b exp 01", grant); end
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    repeat (2) tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
    test_reset();
    test_single_read();
    test_round_robin();
    test_locked_burst();
    test_timeout();
    test_ack_wins();
    test_slave_err();
    test_stb_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish exp finish");
    $fatal(1);
  end

endmodule
